// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch-stage controller: PC register, instruction bus handshake, fetch->decode slot
//
// Ports:
//   clk, reset          clock; synchronous active-low reset (reset==0 resets)
//   pc_selected  [63:0] next PC chosen by pcselect, loaded when stall==0
//   pcsrc        [63:0] redirect target, qualified by jump
//   jump                redirect/flush, kills all younger fetch state
//   pcplus4      [63:0] pc + 4 toward pcselect
//   stall               1 = hold PC (toward pcselect)
//   ireq_valid          instruction request valid
//   ireq_addr    [63:0] request address (always pc)
//   iresp_data_ok       one-cycle response strobe per request
//   iresp_data   [31:0] instruction word, valid with iresp_data_ok
//   dec_ready           decode consumes the slot this cycle
//   f_valid, f_pc, f_instr  fetch->decode slot

module ifetch_ctrl #(
    parameter logic [63:0] PCINIT = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_selected,
    input  logic [63:0] pcsrc,
    input  logic        jump,
    output logic [63:0] pcplus4,
    output logic        stall,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        dec_ready,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr
);

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_DEC = 2'd1,
        S_DISCARD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] pend_pc;
    logic        pend_valid;
    logic [31:0] held_instr;
    logic        slot_free;

    assign slot_free = !f_valid || dec_ready;
    assign pcplus4   = pc + 64'd4;
    assign ireq_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; jump wins over data_ok and dec_ready everywhere
    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (jump && !iresp_data_ok) begin
                    // Request already on the bus cannot be withdrawn: swallow its response
                    state_next = S_DISCARD;
                end else if (!jump && iresp_data_ok && !slot_free) begin
                    state_next = S_WAIT_DEC;
                end
            end
            S_WAIT_DEC: begin
                if (jump || dec_ready) begin
                    state_next = S_REQ;
                end
            end
            S_DISCARD: begin
                if (iresp_data_ok) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        ireq_valid = 1'b0;
        stall      = 1'b1;
        case (state)
            S_REQ: begin
                ireq_valid = reset;
                if (iresp_data_ok && (jump || slot_free)) begin
                    stall = 1'b0;
                end
            end
            S_WAIT_DEC: begin
                if (jump || dec_ready) begin
                    stall = 1'b0;
                end
            end
            S_DISCARD: begin
                ireq_valid = reset;
            end
            default: begin
                ireq_valid = 1'b0;
                stall      = 1'b1;
            end
        endcase
    end

    // PC, pending redirect, held word and the decode slot
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc         <= PCINIT;
            pend_pc    <= 64'd0;
            pend_valid <= 1'b0;
            held_instr <= 32'd0;
            f_valid    <= 1'b0;
            f_pc       <= 64'd0;
            f_instr    <= 32'd0;
        end else begin
            // PC: pcselect path when not stalled; DISCARD reloads internally because
            // the redirect target was captured while the old request was in flight
            if (!stall) begin
                pc <= pc_selected;
            end else if (state == S_DISCARD && iresp_data_ok) begin
                if (jump) begin
                    pc <= pcsrc;
                end else if (pend_valid) begin
                    pc <= pend_pc;
                end
            end

            // Pending redirect target; latest jump wins
            if (state == S_REQ && jump && !iresp_data_ok) begin
                pend_pc    <= pcsrc;
                pend_valid <= 1'b1;
            end else if (state == S_DISCARD) begin
                if (iresp_data_ok) begin
                    pend_valid <= 1'b0;
                end else if (jump) begin
                    pend_pc <= pcsrc;
                end
            end

            // Word returned while decode is blocked waits here until dec_ready
            if (state == S_REQ && !jump && iresp_data_ok && !slot_free) begin
                held_instr <= iresp_data;
            end

            // Decode slot
            if (jump) begin
                f_valid <= 1'b0;
            end else if (state == S_REQ && iresp_data_ok && slot_free) begin
                f_valid <= 1'b1;
                f_pc    <= pc;
                f_instr <= iresp_data;
            end else if (state == S_WAIT_DEC && dec_ready) begin
                f_valid <= 1'b1;
                f_pc    <= pc;
                f_instr <= held_instr;
            end else if (f_valid && dec_ready) begin
                f_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - randomized self-checking bench for ifetch_ctrl against a queue-based fetch model

module tb_ifetch_ctrl;

    localparam logic [63:0] PCINIT = 64'h8000_0000;
    localparam int          NCYC   = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_selected;
    logic [63:0] pcsrc;
    logic        jump;
    logic [63:0] pcplus4;
    logic        stall;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dec_ready;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [31:0] f_instr;

    always #5 clk = ~clk;

    // pcselect stand-in: redirect target on jump, otherwise sequential
    assign pc_selected = jump ? pcsrc : pcplus4;

    ifetch_ctrl #(.PCINIT(PCINIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_selected   (pc_selected),
        .pcsrc         (pcsrc),
        .jump          (jump),
        .pcplus4       (pcplus4),
        .stall         (stall),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dec_ready     (dec_ready),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .f_instr       (f_instr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: instructions delivered but not yet consumed by decode
    // (front = slot, second = word waiting for decode), the address the fetcher
    // must present next, and whether the in-flight response belongs to a killed path.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_fetch;
    logic        m_drop;
    logic [63:0] m_redirect;
    logic        m_init = 1'b0;

    initial begin
        logic        req_exp;
        logic        adv_exp;
        logic [63:0] new_pc;
        ent_t        e;

        reset         = 1'b0;
        jump          = 1'b0;
        pcsrc         = 64'd0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'd0;
        dec_ready     = 1'b0;
        m_fetch       = PCINIT;
        m_drop        = 1'b0;
        m_redirect    = 64'd0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            reset   = (cyc < 2 || $urandom_range(99) == 0) ? 1'b0 : 1'b1;
            req_exp = m_init && (q.size() < 2);
            jump    = ($urandom_range(9) == 0);
            if ($urandom_range(7) == 0) begin
                new_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            end else begin
                new_pc = PCINIT + 64'($urandom_range(4095)) * 64'd4;
            end
            pcsrc         = new_pc;
            iresp_data_ok = reset && req_exp && ($urandom_range(1) == 1);
            iresp_data    = $urandom;
            dec_ready     = ($urandom_range(9) < 6);
            #1;

            if (m_init) begin
                check("ireq_valid", 64'(ireq_valid), 64'(reset && req_exp));
                if (req_exp) begin
                    check("ireq_addr", ireq_addr, m_fetch);
                    check("pcplus4", pcplus4, m_fetch + 64'd4);
                end
                // PC advances through pcselect only when a fetched word is accepted
                // (or killed with a same-cycle redirect), or a waiting word moves on
                adv_exp = (req_exp && !m_drop && iresp_data_ok &&
                           (jump || q.size() == 0 || dec_ready)) ||
                          (!req_exp && (jump || dec_ready));
                check("stall", 64'(stall), 64'(!adv_exp));
                check("f_valid", 64'(f_valid), 64'(q.size() > 0));
                if (q.size() > 0) begin
                    check("f_pc", f_pc, q[0].pc);
                    check("f_instr", 64'(f_instr), 64'(q[0].instr));
                end
            end

            // Model update for this clock edge
            if (!reset) begin
                q.delete();
                m_fetch = PCINIT;
                m_drop  = 1'b0;
                m_init  = 1'b1;
            end else if (m_init) begin
                if (jump) begin
                    if (iresp_data_ok || !req_exp) begin
                        m_fetch = pcsrc;
                        m_drop  = 1'b0;
                    end else begin
                        m_drop     = 1'b1;
                        m_redirect = pcsrc;
                    end
                    q.delete();
                end else begin
                    if (dec_ready && q.size() > 0) begin
                        void'(q.pop_front());
                    end
                    if (iresp_data_ok) begin
                        if (m_drop) begin
                            m_fetch = m_redirect;
                            m_drop  = 1'b0;
                        end else begin
                            e.pc    = m_fetch;
                            e.instr = iresp_data;
                            q.push_back(e);
                            m_fetch = m_fetch + 64'd4;
                        end
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
